serial_bus_slave: RTL and testbench

//  Responder end of the bit-serial system bus driven by the master ports (m1/m2) via the arbiter.

---
 rtl/serial_bus_slave.sv | 214 +++++++++++++++++++++
 tb/tb_serial_bus_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_slave.sv
// Bit-serial bus responder: decodes rw/addr/blen frame, then writes or reads incrementing-wrap bursts to a local register memory.
// Latency: first read bit READ_LAT cycles after the last header bit; writes commit on the edge taking the beat's last bit.
// Backpressure: m_valid gaps stall the frame; s_ready drops during read turnaround/data. Parity beats under `BUS_SLAVE_PARITY_EN.
module serial_bus_slave #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int BURST_W  = 4,
    parameter int READ_LAT = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_s_sel,
    input  logic i_m_valid,
    input  logic i_m_data,
    output logic o_s_ready,
    output logic o_s_valid,
    output logic o_s_data,
    output logic o_s_busy,
    output logic o_s_err
);

`ifdef BUS_SLAVE_PARITY_EN
    localparam int BPB = DATA_W + 1;
`else
    localparam int BPB = DATA_W;
`endif
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BLEN, S_WDATA, S_RWAIT, S_RDATA} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_rw, w_rw_nxt;
    logic [ADDR_W-1:0]    r_addr, w_addr_nxt, w_addr_inc;
    logic [BURST_W-1:0]   r_blen, w_blen_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [BURST_W:0]     r_beat, w_beat_nxt;
    logic [DATA_W-1:0]    r_sh, w_sh_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_data, w_data_nxt;
    logic                 w_acc, w_we;
    logic [DATA_W-1:0]    w_wdat, w_rd_cur, w_rd_next;
    logic [DATA_W-1:0]    r_mem [0:(1<<ADDR_W)-1];
`ifdef BUS_SLAVE_PARITY_EN
    logic                 r_par, w_par_nxt;
    logic                 r_err, w_err_nxt;
`endif

    assign o_s_ready  = i_s_sel && ((r_state == S_IDLE) || (r_state == S_ADDR) ||
                                    (r_state == S_BLEN) || (r_state == S_WDATA));
    assign o_s_busy   = (r_state != S_IDLE);
    assign o_s_valid  = r_valid;
    assign o_s_data   = r_data;
    assign w_acc      = i_m_valid && o_s_ready;
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_rd_cur   = r_mem[r_addr];
    assign w_rd_next  = r_mem[w_addr_inc];
`ifdef BUS_SLAVE_PARITY_EN
    assign o_s_err    = r_err;
`else
    assign o_s_err    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rw_nxt    = r_rw;
        w_addr_nxt  = r_addr;
        w_blen_nxt  = r_blen;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        w_sh_nxt    = r_sh;
        w_valid_nxt = 1'b0;
        w_data_nxt  = 1'b0;
        w_we        = 1'b0;
        w_wdat      = r_sh;
`ifdef BUS_SLAVE_PARITY_EN
        w_par_nxt   = r_par;
        w_err_nxt   = r_err;
`endif
        // Deselect mid-frame abandons the frame; completed beats already sit in memory.
        if ((r_state != S_IDLE) && !i_s_sel) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_acc) begin
                    w_rw_nxt    = i_m_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ADDR;
                end
                S_ADDR: if (w_acc) begin
                    w_addr_nxt = {i_m_data, r_addr[ADDR_W-1:1]};
                    if (r_cnt == CNT_W'(ADDR_W-1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_BLEN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_BLEN: if (w_acc) begin
                    w_blen_nxt = {i_m_data, r_blen[BURST_W-1:1]};
                    w_beat_nxt = '0;
                    if (r_cnt == CNT_W'(BURST_W-1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_rw ? S_RWAIT : S_WDATA;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_WDATA: if (w_acc) begin
                    if (r_cnt == CNT_W'(BPB-1)) begin
`ifdef BUS_SLAVE_PARITY_EN
                        if ((^{r_sh, i_m_data}) == 1'b0) begin
                            w_we   = 1'b1;
                            w_wdat = r_sh;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
`else
                        w_we   = 1'b1;
                        w_wdat = {i_m_data, r_sh[DATA_W-1:1]};
`endif
                        w_addr_nxt = w_addr_inc;
                        w_cnt_nxt  = '0;
                        w_beat_nxt = r_beat + (BURST_W+1)'(1);
                        if (r_beat == {1'b0, r_blen})
                            w_state_nxt = S_IDLE;
                    end else begin
                        w_sh_nxt  = {i_m_data, r_sh[DATA_W-1:1]};
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_RWAIT: begin
                    // Bit 0 is registered on the same edge as the word load so s_valid rises after exactly READ_LAT idle cycles.
                    if (r_cnt == CNT_W'(READ_LAT-1)) begin
                        w_cnt_nxt   = '0;
                        w_sh_nxt    = w_rd_cur;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_rd_cur[0];
`ifdef BUS_SLAVE_PARITY_EN
                        w_par_nxt   = ^w_rd_cur;
`endif
                        w_state_nxt = S_RDATA;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_RDATA: begin
                    if (r_cnt == CNT_W'(BPB-1)) begin
                        if (r_beat == {1'b0, r_blen}) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_addr_nxt  = w_addr_inc;
                            w_beat_nxt  = r_beat + (BURST_W+1)'(1);
                            w_cnt_nxt   = '0;
                            w_sh_nxt    = w_rd_next;
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = w_rd_next[0];
`ifdef BUS_SLAVE_PARITY_EN
                            w_par_nxt   = ^w_rd_next;
`endif
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_sh_nxt    = r_sh >> 1;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_sh[1];
`ifdef BUS_SLAVE_PARITY_EN
                        if (r_cnt == CNT_W'(DATA_W-1))
                            w_data_nxt = r_par;
`endif
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_blen  <= '0;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_sh    <= '0;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
`ifdef BUS_SLAVE_PARITY_EN
            r_par   <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_rw    <= w_rw_nxt;
            r_addr  <= w_addr_nxt;
            r_blen  <= w_blen_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            r_sh    <= w_sh_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
`ifdef BUS_SLAVE_PARITY_EN
            r_par   <= w_par_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we)
            r_mem[r_addr] <= w_wdat;
    end

endmodule

// File: tb/tb_serial_bus_slave.sv
// Randomized bench for serial_bus_slave against a word-array memory model; works with or without BUS_SLAVE_PARITY_EN.
module tb_serial_bus_slave;
    localparam int AW = 4, DW = 8, BW = 4, RL = 2;
`ifdef BUS_SLAVE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, mv = 1'b0, md = 1'b0;
    logic ready, valid, data, busy, err;
    int   n_checks = 0, n_fail = 0;
    logic [7:0] model_mem [16];

    serial_bus_slave #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .READ_LAT(RL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_s_sel(sel), .i_m_valid(mv), .i_m_data(md),
        .o_s_ready(ready), .o_s_valid(valid), .o_s_data(data), .o_s_busy(busy), .o_s_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        mv = 1'b0;
        repeat (g) begin
            md = 1'($urandom);
            step();
        end
        mv = 1'b1;
        md = b;
        step();
        mv = 1'b0;
        md = 1'b0;
    endtask

    task automatic send_header(input logic rw, input logic [3:0] a, input logic [3:0] bl, input int gap);
        send_bit(rw, gap);
        for (int i = 0; i < AW; i++) send_bit(a[i], gap);
        for (int i = 0; i < BW; i++) send_bit(bl[i], gap);
    endtask

    task automatic write_frame(input logic [3:0] a, input logic [3:0] bl, input logic [7:0] d [16], input int gap);
        logic [3:0] wa;
        send_header(1'b0, a, bl, gap);
        for (int k = 0; k <= int'(bl); k++) begin
            for (int i = 0; i < DW; i++) send_bit(d[k][i], gap);
            if (PAR == 1) send_bit(^d[k], gap);
            wa = a + 4'(k);
            model_mem[wa] = d[k];
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] bl, input int gap, input string name);
        logic [7:0] got;
        logic [3:0] ra;
        logic       gp;
        bit         vok;
        send_header(1'b1, a, bl, gap);
        for (int i = 0; i < RL; i++) begin
            n_checks++;
            if ({valid, data} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s turnaround cycle %0d: valid,data=%b%b required 00", name, i, valid, data);
            end
            step();
        end
        for (int k = 0; k <= int'(bl); k++) begin
            vok = 1'b1;
            got = '0;
            gp  = 1'b0;
            for (int i = 0; i < DW + PAR; i++) begin
                if (valid !== 1'b1) vok = 1'b0;
                if (i < DW) got[i] = data;
                else        gp     = data;
                step();
            end
            ra = a + 4'(k);
            n_checks++;
            if (!vok || got !== model_mem[ra]) begin
                n_fail++;
                $display("FAIL %s beat %0d addr %0d: got %h valid_ok=%0d required %h", name, k, ra, got, vok, model_mem[ra]);
            end
            if (PAR == 1) begin
                n_checks++;
                if (gp !== ^model_mem[ra]) begin
                    n_fail++;
                    $display("FAIL %s parity beat %0d: got %b required %b", name, k, gp, ^model_mem[ra]);
                end
            end
        end
        n_checks++;
        if ({valid, data, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s end: valid,data,busy=%b%b%b required 000", name, valid, data, busy);
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({busy, valid, data, err, ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_state: busy,valid,data,err,ready=%b%b%b%b%b required 00000", busy, valid, data, err, ready);
        end
        step();
        rst_n = 1'b1;
        sel   = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: s_ready=%b required 1", ready);
        end
        step();
    endtask

    task automatic test_fill();
        logic [7:0] d [16];
        for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
        write_frame(4'd0, 4'd15, d, 0);
        do_read(4'd0, 4'd15, 0, "fill_full_burst");
        do_read(4'($urandom_range(15, 0)), 4'd15, 0, "fill_offset_burst");
    endtask

    task automatic test_single();
        logic [7:0] d [16];
        d[0] = 8'hA5;
        write_frame(4'd3, 4'd0, d, 0);
        do_read(4'd3, 4'd0, 0, "single_A5");
    endtask

    task automatic test_burst_wrap();
        logic [7:0] d [16];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        write_frame(4'd14, 4'd3, d, 0);
        do_read(4'd0, 4'd1, 0, "wrap_read_0");
        do_read(4'd14, 4'd3, 0, "wrap_read_14");
    endtask

    task automatic test_stall();
        logic [7:0] d [16];
        logic [3:0] a, bl;
        for (int n = 0; n < 6; n++) begin
            a  = 4'($urandom_range(15, 0));
            bl = 4'($urandom_range(3, 0));
            for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
            write_frame(a, bl, d, 3);
            do_read(a, bl, 2, "stall_readback");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [16];
        d[0] = 8'($urandom);
        d[1] = 8'($urandom);
        write_frame(4'd2, 4'd1, d, 0);
        do_read(4'd2, 4'd0, 0, "b2b_first");
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: s_ready=%b required 1", ready);
        end
        do_read(4'd3, 4'd0, 0, "b2b_second");
    endtask

    task automatic test_abort();
        logic [7:0] d [16];
        d[0] = 8'h3C;
        write_frame(4'd5, 4'd0, d, 0);
        send_header(1'b0, 4'd5, 4'd0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        sel = 1'b0;
        step();
        n_checks++;
        if ({busy, ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_write_busy: busy,ready=%b%b required 00", busy, ready);
        end
        sel = 1'b1;
        do_read(4'd5, 4'd0, 0, "abort_write_keep");
        // Burst abort keeps the completed first beat only.
        d[0] = 8'($urandom);
        send_header(1'b0, 4'd6, 4'd2, 0);
        for (int i = 0; i < DW; i++) send_bit(d[0][i], 0);
        if (PAR == 1) send_bit(^d[0], 0);
        model_mem[6] = d[0];
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
        sel = 1'b0;
        step();
        sel = 1'b1;
        do_read(4'd6, 4'd2, 0, "abort_burst_partial");
        send_header(1'b1, 4'd5, 4'd3, 0);
        repeat (RL + 5) step();
        sel = 1'b0;
        step();
        n_checks++;
        if ({valid, data, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_read: valid,data,busy=%b%b%b required 000", valid, data, busy);
        end
        sel = 1'b1;
        do_read(4'd5, 4'd1, 0, "after_read_abort");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d [16];
        d[0] = 8'($urandom);
        d[1] = 8'($urandom);
        send_header(1'b0, 4'd9, 4'd1, 0);
        for (int i = 0; i < DW; i++) send_bit(d[0][i], 0);
        if (PAR == 1) send_bit(^d[0], 0);
        model_mem[9] = d[0];
        for (int i = 0; i < 3; i++) send_bit(d[1][i], 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid, data, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid: busy,valid,data,err=%b%b%b%b required 0000", busy, valid, data, err);
        end
        step();
        rst_n = 1'b1;
        step();
        do_read(4'd9, 4'd1, 0, "reset_mid_readback");
    endtask

`ifdef BUS_SLAVE_PARITY_EN
    task automatic test_parity();
        logic [7:0] d [16];
        send_header(1'b0, 4'd7, 4'd0, 0);
        for (int i = 0; i < DW; i++) send_bit(i == 0, 0);
        send_bit(1'b0, 0);
        n_checks++;
        if ({err, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL parity_err_set: err,busy=%b%b required 10", err, busy);
        end
        do_read(4'd7, 4'd0, 0, "parity_bad_not_written");
        d[0] = 8'h03;
        write_frame(4'd8, 4'd0, d, 0);
        do_read(4'd8, 4'd0, 0, "parity_read_03");
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_err_sticky: err=%b required 1", err);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err_clear: err=%b required 0", err);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_burst_wrap();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef BUS_SLAVE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
